// File: rtl/wb_master_ctrl.sv
// Single-outstanding Wishbone classic master: one command in, one bus cycle out, one response pulse back.
// Optional bus-cycle timeout is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl #(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I,
  input  logic        ERR_I,
  input  logic        RTY_I
);

  localparam int            RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [1:0]    ST_OK       = 2'b00;
  localparam logic [1:0]    ST_ERR      = 2'b01;
  localparam logic [1:0]    ST_RTY      = 2'b10;

  typedef enum logic [1:0] {IDLE, BUS, RETRY_WAIT, RESP} state_t;

  state_t        state;
  logic [RW-1:0] retry_cnt;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    ST_TMO   = 2'b11;
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      CYC_O      <= 1'b0;
      STB_O      <= 1'b0;
      WE_O       <= 1'b0;
      ADR_O      <= '0;
      DAT_O      <= '0;
      SEL_O      <= '0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;
      retry_cnt  <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            WE_O      <= cmd_we;
            ADR_O     <= cmd_adr;
            DAT_O     <= cmd_dat;
            SEL_O     <= cmd_sel;
            retry_cnt <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            CYC_O     <= 1'b1;
            STB_O     <= 1'b1;
            state     <= BUS;
          end
        end
        BUS: begin
          // ERR outranks RTY, which outranks ACK, when several arrive together
          if (ERR_I) begin
            CYC_O      <= 1'b0;
            STB_O      <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= '0;
            rsp_status <= ST_ERR;
            state      <= RESP;
          end else if (RTY_I && (retry_cnt < RETRY_LIMIT)) begin
            retry_cnt <= retry_cnt + 1'b1;
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            state     <= RETRY_WAIT;
          end else if (RTY_I) begin
            CYC_O      <= 1'b0;
            STB_O      <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= '0;
            rsp_status <= ST_RTY;
            state      <= RESP;
          end else if (ACK_I) begin
            CYC_O      <= 1'b0;
            STB_O      <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= WE_O ? 32'h0 : DAT_I;
            rsp_status <= ST_OK;
            state      <= RESP;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            CYC_O      <= 1'b0;
            STB_O      <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= '0;
            rsp_status <= ST_TMO;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RETRY_WAIT: begin
          // address/data/select stay latched across the one-cycle gap
          CYC_O <= 1'b1;
          STB_O <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= BUS;
        end
        RESP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: fixed vector table, reset/timeout corner sequences, randomized traffic vs. a reference model.
module tb_wb_master_ctrl;
  localparam int MAXR = 3;
  localparam int TMO  = 64;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  // termination code bits: [0] ACK, [1] ERR, [2] RTY
  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_ACK  = 3'b001;
  localparam logic [2:0] T_ERR  = 3'b010;
  localparam logic [2:0] T_RTY  = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic [31:0] DAT_I = '0;
  logic        ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;

  always #5 clk = ~clk;

  wb_master_ctrl #(.MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          n_rty;     // leading attempts the slave answers with RTY
    int          waits;     // wait states before each termination
    logic [2:0]  fin;       // termination used once the leading RTYs are spent
    logic [1:0]  exp_status;
    logic [31:0] exp_dat;
    int          exp_att;
    int          exp_cyc;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          got;
    bit          stable;
    bit          rsp_after;
    bit          ready_after;
    bit          cyc_at_rsp;
    logic [1:0]  status;
    logic [31:0] dat;
    int          attempts;
    int          cyc;
    int          lat;
  } obs_t;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [31:0] rd, input int nr, input int w,
                              input logic [2:0] fin, input logic [1:0] st, input logic [31:0] ed,
                              input int att, input int cyc, input int lat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.rdata = rd;
    v.n_rty = nr; v.waits = w; v.fin = fin;
    v.exp_status = st; v.exp_dat = ed; v.exp_att = att; v.exp_cyc = cyc; v.exp_lat = lat;
    return v;
  endfunction

  // Reference: walk the attempts the slave will answer and apply the termination rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [2:0] term;
    r = v;
    r.exp_status = 2'b00; r.exp_dat = '0; r.exp_att = 0; r.exp_cyc = 0;
    for (int a = 0; a <= MAXR; a++) begin
      term = (a < v.n_rty) ? T_RTY : v.fin;
      r.exp_att = a + 1;
      if (term == T_NONE) begin
        r.exp_cyc += TMO;
        r.exp_status = 2'b11;
        break;
      end
      r.exp_cyc += v.waits + 1;
      if (term[1]) begin
        r.exp_status = 2'b01;
        break;
      end
      if (term[2]) begin
        if (a < MAXR) continue;
        r.exp_status = 2'b10;
        break;
      end
      r.exp_status = 2'b00;
      r.exp_dat = v.we ? 32'h0 : v.rdata;
      break;
    end
    r.exp_lat = r.exp_cyc + r.exp_att;
    return r;
  endfunction

  // Issue one command and play the slave; everything is sampled on the falling edge.
  task automatic do_txn(input vec_t v, input bit junk, output obs_t o);
    int wcnt, guard;
    bit in_cyc;
    logic [2:0] term, jb;
    o.got = 0; o.stable = 1; o.rsp_after = 1; o.ready_after = 0; o.cyc_at_rsp = 1;
    o.status = '0; o.dat = '0; o.attempts = 0; o.cyc = 0; o.lat = 0;
    wcnt = 0; in_cyc = 0; guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
      DAT_I = $urandom;
      if (rsp_valid) begin
        o.got = 1; o.lat = c; o.status = rsp_status; o.dat = rsp_dat; o.cyc_at_rsp = CYC_O;
        @(negedge clk);
        o.rsp_after = rsp_valid;
        o.ready_after = cmd_ready;
        break;
      end
      if (CYC_O) begin
        if (!in_cyc) begin
          in_cyc = 1; wcnt = 0; o.attempts++;
        end
        o.cyc++;
        if (ADR_O !== v.adr || DAT_O !== v.dat || SEL_O !== v.sel || WE_O !== v.we || STB_O !== 1'b1)
          o.stable = 0;
        if (wcnt == v.waits) begin
          term = (o.attempts <= v.n_rty) ? T_RTY : v.fin;
          ACK_I = term[0]; ERR_I = term[1]; RTY_I = term[2];
          DAT_I = v.rdata;
        end
        wcnt++;
      end else begin
        in_cyc = 0;
        if (junk) begin
          jb = 3'($urandom);
          ACK_I = jb[0]; ERR_I = jb[1]; RTY_I = jb[2];
        end
      end
    end
    ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit junk, input string tag);
    obs_t o;
    do_txn(v, junk, o);
    chk({tag, " response seen"}, 32'(o.got), 32'd1);
    chk({tag, " status"}, 32'(o.status), 32'(v.exp_status));
    chk({tag, " rsp_dat"}, o.dat, v.exp_dat);
    chk({tag, " bus attempts"}, o.attempts, v.exp_att);
    chk({tag, " CYC cycles"}, o.cyc, v.exp_cyc);
    chk({tag, " latency"}, o.lat, v.exp_lat);
    chk({tag, " bus fields stable"}, 32'(o.stable), 32'd1);
    chk({tag, " CYC low at rsp"}, 32'(o.cyc_at_rsp), 32'd0);
    chk({tag, " rsp one cycle"}, 32'(o.rsp_after), 32'd0);
    chk({tag, " ready after rsp"}, 32'(o.ready_after), 32'd1);
  endtask

  // Start a read against a silent slave, hold it, then pulse reset mid wait-state.
  task automatic reset_mid(input int hold);
    int held, quiet, rdy, guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cmd_we = 1'b0; cmd_adr = 32'h2000; cmd_dat = 32'h0; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    held = 0;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (CYC_O && STB_O && !rsp_valid) held++;
    end
    chk("silent slave CYC held", held, hold);
    #2 rst = 1'b1;
    #1;
    chk("mid-rst CYC_O", 32'(CYC_O), 32'd0);
    chk("mid-rst STB_O", 32'(STB_O), 32'd0);
    chk("mid-rst ADR_O", ADR_O, 32'h0);
    chk("mid-rst SEL_O", 32'(SEL_O), 32'd0);
    chk("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid-rst cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0; rdy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!rsp_valid && !CYC_O) quiet++;
      if (cmd_ready) rdy++;
    end
    chk("post-rst no rsp/CYC", quiet, 4);
    chk("post-rst cmd_ready", rdy, 4);
  endtask

  vec_t tbl[9];
  vec_t v;
  logic [2:0] fins[6];

  initial begin
    tbl[0] = mk(1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0, T_ACK,         2'b00, 32'hDEADBEEF, 1, 1, 2);
    tbl[1] = mk(1'b1, 32'h0000_0010, 32'h12345678, 4'hF, 32'hA5A5A5A5, 0, 3, T_ACK,  2'b00, 32'h0, 1, 4, 5);
    tbl[2] = mk(1'b0, 32'h0000_0040, 32'h0, 4'h3, 32'hCAFEF00D, 2, 0, T_ACK,         2'b00, 32'hCAFEF00D, 3, 3, 6);
    tbl[3] = mk(1'b0, 32'h0000_0044, 32'h0, 4'hF, 32'h11111111, 0, 0, T_RTY,         2'b10, 32'h0, 4, 4, 8);
    tbl[4] = mk(1'b0, 32'h0000_0048, 32'h0, 4'hF, 32'h22222222, 0, 1, T_ERR | T_ACK, 2'b01, 32'h0, 1, 2, 3);
    tbl[5] = mk(1'b1, 32'h0000_004C, 32'h33333333, 4'h1, 32'h0, 0, 0, T_ERR,         2'b01, 32'h0, 1, 1, 2);
    tbl[6] = mk(1'b0, 32'h0000_0050, 32'h0, 4'hF, 32'h44444444, 0, 0, T_RTY | T_ACK, 2'b10, 32'h0, 4, 4, 8);
    tbl[7] = mk(1'b0, 32'h0000_0054, 32'h0, 4'hC, 32'h55555555, 3, 1, T_ACK,         2'b00, 32'h55555555, 4, 8, 12);
    tbl[8] = mk(1'b0, 32'h0000_0058, 32'h0, 4'hF, 32'h66666666, 4, 0, T_ACK,         2'b10, 32'h0, 4, 4, 8);
    fins[0] = T_ACK; fins[1] = T_ERR; fins[2] = T_ERR | T_ACK;
    fins[3] = T_RTY; fins[4] = T_RTY | T_ACK; fins[5] = T_ERR | T_RTY;

    repeat (2) @(negedge clk);
    chk("reset CYC_O", 32'(CYC_O), 32'd0);
    chk("reset STB_O", 32'(STB_O), 32'd0);
    chk("reset WE_O", 32'(WE_O), 32'd0);
    chk("reset ADR_O", ADR_O, 32'h0);
    chk("reset DAT_O", DAT_O, 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_dat", rsp_dat, 32'h0);
    chk("reset rsp_status", 32'(rsp_status), 32'd0);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1 chk("cmd_ready before first edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("cmd_ready after first edge", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

    reset_mid(TMO_EN ? 3 : 210);
    run_vec(tbl[0], 1'b0, "after-reset read");

    if (TMO_EN) begin
      v = mk(1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'h0, 0, 0, T_NONE, 2'b00, 32'h0, 0, 0, 0);
      run_vec(model(v), 1'b0, "timeout");
    end

    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom); v.adr = $urandom; v.dat = $urandom; v.sel = 4'($urandom);
      v.rdata = $urandom; v.n_rty = $urandom_range(0, 4); v.waits = $urandom_range(0, 3);
      v.fin = fins[$urandom_range(0, 5)];
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_vec(model(v), 1'b1, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_master_ctrl.md
WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 Parameter: MAX_RETRY, 3, RTY_I terminations retried before giving up (0 = no retry).
REQ-002 Parameter: TIMEOUT_CYCLES, 64, bus cycles without termination before abort (with WB_MASTER_TIMEOUT_EN).
REQ-003 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: cmd_valid  input  1  command request.
REQ-006 Port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge.
REQ-007 Port: cmd_we / cmd_adr / cmd_dat / cmd_sel  input  1/32/32/4  write flag, address, write data, byte selects.
REQ-008 Port: rsp_valid  output  1  one-cycle response pulse.
REQ-009 Port: rsp_dat  output  32  read data (0 for writes and failed cycles).
REQ-010 Port: rsp_status  output  2  00 OK, 01 ERR, 10 retries exhausted, 11 timeout.
REQ-011 Port: CYC_O, STB_O, WE_O  output  1 each  Wishbone cycle, strobe, write enable.
REQ-012 Port: ADR_O / DAT_O / SEL_O  output  32/32/4  Wishbone address, write data, selects.
REQ-013 Port: DAT_I  input  32  Wishbone read data.
REQ-014 Port: ACK_I, ERR_I, RTY_I  input  1 each  Wishbone terminations.

Function
REQ-015 FSM states IDLE, BUS, RETRY_WAIT, RESP; all outputs registered.
REQ-016 cmd_ready = 1 only in IDLE; on accept, cmd fields latched, retry and timeout counters cleared, -> BUS.
REQ-017 BUS: CYC_O=STB_O=1; WE_O/ADR_O/DAT_O/SEL_O drive latched cmd, stable for the whole transaction including retries.
REQ-018 Terminations sampled at posedge in BUS only; ignored in every other state.
REQ-019 Priority when simultaneous: ERR_I > RTY_I > ACK_I.
REQ-020 ACK_I: latch DAT_I if read (rsp_dat=0 if write), status 00, CYC_O/STB_O low next cycle, -> RESP.
REQ-021 ERR_I: status 01, rsp_dat 0, -> RESP.
REQ-022 RTY_I with retry_cnt < MAX_RETRY: retry_cnt+1, -> RETRY_WAIT (CYC_O=STB_O=0 one cycle), then -> BUS.
REQ-023 RTY_I with retry_cnt == MAX_RETRY: status 10, rsp_dat 0, -> RESP.
REQ-024 RESP: rsp_valid=1 for exactly one cycle, CYC_O=STB_O=0, -> IDLE.
REQ-025 Latency, zero-wait ACK: accept at edge E0; CYC high after E0; ACK sampled at E1; rsp_valid high E1..E2; cmd_ready high after E2 (3 cycles/transaction).
REQ-026 Wait states: CYC_O/STB_O held until termination; no limit without timeout feature.
REQ-027 retry_cnt width $clog2(MAX_RETRY+1); counts never wrap.

Reset
REQ-028 rst asserted: immediately (asynchronously) CYC_O=STB_O=WE_O=0, ADR_O=DAT_O=0, SEL_O=0, rsp_valid=0, rsp_dat=0, rsp_status=00, counters 0, state IDLE, cmd_ready=0 while rst high.
REQ-029 Reset mid-transaction aborts the bus cycle with no rsp_valid; the in-flight command is discarded.
REQ-030 After rst deasserts, cmd_ready=1 from the first posedge.

Configuration
REQ-031 Macro WB_MASTER_TIMEOUT_EN defined: timeout counter increments each BUS cycle without termination; reaching TIMEOUT_CYCLES gives status 11, rsp_dat 0, CYC_O low, -> RESP; counter clears on entering BUS (incl. after retry).
REQ-032 WB_MASTER_TIMEOUT_EN undefined: no timeout counter in RTL; status 11 never produced; TIMEOUT_CYCLES unused.

Verification
REQ-033 Read adr 0x0000_1000, slave ACK 0 waits with DAT_I=0xDEADBEEF -> rsp_valid at E1, rsp_dat 0xDEADBEEF, status 00, CYC high exactly 1 cycle.
REQ-034 Write adr 0x10, dat 0x12345678, sel 0xF, ACK after 3 waits -> DAT_O/ADR_O/SEL_O stable 4 cycles, rsp_dat 0, status 00.
REQ-035 MAX_RETRY=3, slave RTY twice then ACK -> two 1-cycle CYC gaps, status 00; slave always RTY -> 4 bus attempts, status 10.
REQ-036 ERR_I and ACK_I asserted together -> status 01, rsp_dat 0.
REQ-037 Timeout enabled, TIMEOUT_CYCLES=64, silent slave -> CYC dropped after 64 cycles, status 11; disabled build -> CYC held 200+ cycles.
REQ-038 rst pulsed mid wait-state -> CYC_O/STB_O low same cycle, no rsp_valid, next command completes normally.
